// File: rtl/cylon_seq.sv
// cylon_seq: slow LED pattern generator (bounce/walk/fill/blink) with startup hold-off,
// run/freeze with single-step and bounce end dwell. Optional comet trail: CYLON_TRAIL_EN.
module cylon_seq #(
    parameter int NLED  = 8,
    parameter int MXPOS = 3,
    parameter int MXPRE = 21,
    parameter int DWELL = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             step,
    output logic             tick_out,
    output logic [MXPOS-1:0] pos,
    output logic [NLED-1:0]  q
);

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_DWELL = 2'd2} state_t;

    localparam logic [MXPOS-1:0] LAST    = MXPOS'(NLED - 1);
    localparam logic [MXPOS-1:0] ZERO    = '0;
    localparam logic [3:0]       DWELL_C = 4'(DWELL);

    state_t            r_state, w_state_nx;
    logic [MXPRE-1:0]  r_prescaler;
    logic [MXPOS-1:0]  r_pos, w_pos_nx, w_adv_pos;
    logic              r_dir_dn, w_dir_nx, w_adv_dir_dn, w_adv_end;
    logic [3:0]        r_dwell, w_dwell_nx;
    logic [1:0]        r_init_cnt, w_init_nx;
    logic [1:0]        r_mode;
    logic              r_step_d, r_tick_out;
    logic [NLED-1:0]   r_q, w_q_nx;
    logic              w_tick, w_adv, w_mode_chg;
`ifdef CYLON_TRAIL_EN
    logic [MXPOS-1:0]  r_prev_pos, w_prev_nx;
`endif

    assign w_tick     = (r_prescaler == '0);
    assign w_adv      = run ? w_tick : (step & ~r_step_d);
    assign w_mode_chg = (mode != r_mode);

    // Position and direction that one advance would produce in the current mode
    always_comb begin
        w_adv_pos    = r_pos;
        w_adv_dir_dn = r_dir_dn;
        w_adv_end    = 1'b0;
        if (r_pos > LAST) begin
            w_adv_pos    = ZERO;
            w_adv_dir_dn = 1'b0;
        end else begin
            case (r_mode)
                2'd0: begin
                    w_adv_pos    = r_dir_dn ? (r_pos - MXPOS'(1)) : (r_pos + MXPOS'(1));
                    w_adv_end    = (w_adv_pos == LAST) || (w_adv_pos == ZERO);
                    w_adv_dir_dn = w_adv_end ? ~r_dir_dn : r_dir_dn;
                end
                2'd1, 2'd2: w_adv_pos = (r_pos == LAST) ? ZERO : (r_pos + MXPOS'(1));
                2'd3:       w_adv_pos = (r_pos == ZERO) ? MXPOS'(1) : ZERO;
                default:    w_adv_pos = ZERO;
            endcase
        end
    end

    // Next-state logic: hold-off, restart on mode change, advance and dwell
    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_dir_nx   = r_dir_dn;
        w_dwell_nx = r_dwell;
        w_init_nx  = r_init_cnt;
`ifdef CYLON_TRAIL_EN
        w_prev_nx  = r_prev_pos;
`endif
        case (r_state)
            ST_INIT: begin
                w_pos_nx  = ZERO;
                w_init_nx = r_init_cnt + 2'd1;
`ifdef CYLON_TRAIL_EN
                w_prev_nx = ZERO;
`endif
                if (r_init_cnt == 2'd2) w_state_nx = ST_RUN;
                else                    w_state_nx = ST_INIT;
            end
            ST_RUN, ST_DWELL: begin
                if (w_mode_chg) begin
                    w_state_nx = ST_RUN;
                    w_pos_nx   = ZERO;
                    w_dir_nx   = 1'b0;
                    w_dwell_nx = 4'd0;
`ifdef CYLON_TRAIL_EN
                    w_prev_nx  = ZERO;
`endif
                end else if (w_adv && (r_state == ST_DWELL) && (r_dwell != 4'd0)) begin
                    w_dwell_nx = r_dwell - 4'd1;
                end else if (w_adv) begin
                    w_pos_nx = w_adv_pos;
                    w_dir_nx = w_adv_dir_dn;
`ifdef CYLON_TRAIL_EN
                    w_prev_nx = r_pos;
`endif
                    if ((r_state == ST_RUN) && (r_mode == 2'd0) && (DWELL_C != 4'd0) && w_adv_end) begin
                        w_state_nx = ST_DWELL;
                        w_dwell_nx = DWELL_C;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: w_state_nx = ST_INIT;
        endcase
    end

    // LED pattern decode from the registered position
    always_comb begin
        w_q_nx = '0;
        if (r_state == ST_INIT) begin
            w_q_nx = '0;
        end else begin
            for (int i = 0; i < NLED; i++) begin
                case (r_mode)
                    2'd0, 2'd1: begin
                        w_q_nx[i] = (MXPOS'(i) == r_pos);
`ifdef CYLON_TRAIL_EN
                        // In dwell the comet tail folds onto the head
                        if (r_state != ST_DWELL) w_q_nx[i] = w_q_nx[i] | (MXPOS'(i) == r_prev_pos);
                        else                     w_q_nx[i] = w_q_nx[i];
`endif
                    end
                    2'd2:    w_q_nx[i] = (MXPOS'(i) <= r_pos);
                    2'd3:    w_q_nx[i] = (r_pos == ZERO);
                    default: w_q_nx[i] = 1'b0;
                endcase
            end
        end
    end

    // State, position and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_prescaler <= '0;
            r_pos       <= '0;
            r_dir_dn    <= 1'b0;
            r_dwell     <= 4'd0;
            r_init_cnt  <= 2'd0;
            r_mode      <= 2'd0;
            r_step_d    <= 1'b0;
            r_tick_out  <= 1'b0;
            r_q         <= '0;
`ifdef CYLON_TRAIL_EN
            r_prev_pos  <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_prescaler <= r_prescaler + MXPRE'(1);
            r_pos       <= w_pos_nx;
            r_dir_dn    <= w_dir_nx;
            r_dwell     <= w_dwell_nx;
            r_init_cnt  <= w_init_nx;
            r_mode      <= mode;
            r_step_d    <= step;
            r_tick_out  <= w_tick;
            r_q         <= w_q_nx;
`ifdef CYLON_TRAIL_EN
            r_prev_pos  <= w_prev_nx;
`endif
        end
    end

    assign tick_out = r_tick_out;
    assign pos      = r_pos;
    assign q        = r_q;

endmodule

// File: tb/tb_cylon_seq.sv
// Directed bench for cylon_seq: NLED=8, MXPRE=4 (tick every 16 clocks); a second
// instance with DWELL=2 shares all inputs and is checked during the bounce run.
module tb_cylon_seq;

    logic       clock = 1'b0;
    logic       reset_n, run, step;
    logic [1:0] mode;
    logic       tick_out, tick_out_d;
    logic [2:0] pos, pos_d;
    logic [7:0] q, q_d;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    logic [7:0] bnc [0:13];
    logic [7:0] dwl [0:17];
    logic [7:0] fil [0:7];
    logic [7:0] wlk [0:7];

    cylon_seq #(.NLED(8), .MXPOS(3), .MXPRE(4), .DWELL(0)) u_dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .run(run), .step(step),
        .tick_out(tick_out), .pos(pos), .q(q)
    );

    cylon_seq #(.NLED(8), .MXPOS(3), .MXPRE(4), .DWELL(2)) u_dwl (
        .clock(clock), .reset_n(reset_n), .mode(mode), .run(run), .step(step),
        .tick_out(tick_out_d), .pos(pos_d), .q(q_d)
    );

    always #5 clock = ~clock;

    task automatic step_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        bnc = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        dwl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01, 8'h01};
        fil = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
        wlk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        reset_n = 1'b0;
        mode    = 2'd0;
        run     = 1'b1;
        step    = 1'b0;
        step_clk(3);
        chk("rst_q", q, 8'h00);
        chk("rst_pos", {5'd0, pos}, 8'h00);
        chk("rst_tick", {7'd0, tick_out}, 8'h00);

        // Release between edges; the next rising edge is clock 1
        reset_n = 1'b1;
        step_clk(1);
        chk("init_q_c1", q, 8'h00);
        chk("tick_out_c1", {7'd0, tick_out}, 8'h01);
        step_clk(2);
        chk("init_q_c3", q, 8'h00);
        chk("tick_out_c3", {7'd0, tick_out}, 8'h00);
        step_clk(1);
        chk("start_q_c4", q, 8'h01);
        chk("start_dwl_c4", q_d, 8'h01);
        step_clk(13);
        chk("adv_pos_c17", {5'd0, pos}, 8'h01);
        chk("adv_q_lag_c17", q, 8'h01);

        // Bounce: one step per tick, DWELL=0 period 14, DWELL=2 period 18
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) step_clk(16);
            else       step_clk(1);
            chk($sformatf("bounce_k%0d", k), q, bnc[k % 14]);
            chk($sformatf("dwell_k%0d", k), q_d, dwl[k % 18]);
        end
        chk("bounce_pos5", {5'd0, pos}, 8'h05);

        // Switch to fill at pos 5
        mode = 2'd2;
        step_clk(1);
        chk("fill_restart_pos", {5'd0, pos}, 8'h00);
        step_clk(1);
        chk("fill_restart_q", q, 8'h01);
        step_clk(14);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step_clk(16);
            chk($sformatf("fill_%0d", i), q, fil[i]);
        end

        mode = 2'd1;
        step_clk(2);
        chk("walk_start", q, 8'h01);
        step_clk(14);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step_clk(16);
            chk($sformatf("walk_%0d", i), q, wlk[i]);
        end

        mode = 2'd3;
        step_clk(2);
        chk("blink_0", q, 8'hFF);
        step_clk(14);
        chk("blink_1", q, 8'h00);
        step_clk(16);
        chk("blink_2", q, 8'hFF);
        step_clk(16);
        chk("blink_3", q, 8'h00);

        // Frozen in walk mode for 100 ticks
        mode = 2'd1;
        run  = 1'b0;
        step_clk(2);
        chk("freeze_start_q", q, 8'h01);
        step_clk(1597);
        chk("freeze_q", q, 8'h01);
        chk("freeze_tick_out", {7'd0, tick_out}, 8'h01);
        step_clk(1);
        chk("freeze_tick_low", {7'd0, tick_out}, 8'h00);
        chk("freeze_pos", {5'd0, pos}, 8'h00);

        // Single-clock step pulse
        step = 1'b1;
        step_clk(1);
        step = 1'b0;
        chk("step1_pos", {5'd0, pos}, 8'h01);
        step_clk(1);
        chk("step1_q", q, 8'h02);
        step_clk(5);
        chk("step1_hold", q, 8'h02);

        // Step held for 40 clocks gives one advance
        step = 1'b1;
        step_clk(40);
        chk("step40_pos", {5'd0, pos}, 8'h02);
        chk("step40_q", q, 8'h04);
        step = 1'b0;
        step_clk(3);
        chk("step40_after", {5'd0, pos}, 8'h02);

        // Back to bounce, then asynchronous reset between edges
        mode = 2'd0;
        run  = 1'b1;
        step_clk(40);
        chk("rebounce_q", q, 8'h04);
        chk("rebounce_pos", {5'd0, pos}, 8'h02);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_q", q, 8'h00);
        chk("async_rst_pos", {5'd0, pos}, 8'h00);
        chk("async_rst_dwl_q", q_d, 8'h00);
        step_clk(2);
        reset_n = 1'b1;
        step_clk(3);
        chk("reinit_q_c3", q, 8'h00);
        step_clk(1);
        chk("reinit_q_c4", q, 8'h01);
        step_clk(14);
        chk("reinit_first_adv", q, 8'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
